// File: rtl/snax_csr_pkg.sv
// Shared types and address-map helpers for the SNAX CSR manager.
// Optional PERF counter is enabled with SNAX_CSR_PERF_EN.
package snax_csr_pkg;

  localparam int unsigned MaxIdWidth = 16;

  typedef enum logic [0:0] {
    LaunchIdle    = 1'b0,
    LaunchPending = 1'b1
  } launch_state_e;

  typedef struct packed {
    logic [31:0]           data;
    logic [MaxIdWidth-1:0] id;
    logic                  error;
  } rsp_entry_t;

  function automatic int unsigned start_idx(
    input int unsigned nrw
  );
    return nrw;
  endfunction

  function automatic int unsigned perf_idx(
    input int unsigned nrw,
    input int unsigned nro
  );
    return nrw + nro + 1;
  endfunction

  function automatic int unsigned dec_width(
    input int unsigned nrw,
    input int unsigned nro
  );
    return $clog2(nrw + nro + 2);
  endfunction

endpackage

// File: rtl/snax_csr_manager_fifo.sv
// Registered response queue (fifo_v3 semantics, no fall-through).
// A push into a full queue is taken when a pop happens in the same cycle.
module snax_csr_manager_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          full_o,
  output logic          empty_o,
  input  logic [DW-1:0] data_i,
  input  logic          push_i,
  output logic [DW-1:0] data_o,
  input  logic          pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_cnt;

  logic w_do_pop;
  logic w_do_push;

  assign full_o    = (r_cnt == CntW'(DEPTH));
  assign empty_o   = (r_cnt == '0);
  assign data_o    = r_mem[r_rptr];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= data_i;
        if (r_wptr == PtrW'(DEPTH - 1)) r_wptr <= '0;
        else                            r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        if (r_rptr == PtrW'(DEPTH - 1)) r_rptr <= '0;
        else                            r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/snax_csr_manager.sv
// CSR manager between the Snitch offload port and a SNAX accelerator.
// Define SNAX_CSR_PERF_EN to add the busy-cycle PERF counter.
module snax_csr_manager
  import snax_csr_pkg::*;
#(
  parameter int unsigned NumRwCsr     = 8,
  parameter int unsigned NumRoCsr     = 2,
  parameter int unsigned RspFifoDepth = 2,
  parameter int unsigned IdWidth      = 5,
  parameter int unsigned CsrAddrWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      csr_req_valid_i,
  output logic                      csr_req_ready_o,
  input  logic [CsrAddrWidth-1:0]   csr_req_addr_i,
  input  logic [31:0]               csr_req_data_i,
  input  logic                      csr_req_write_i,
  input  logic [IdWidth-1:0]        csr_req_id_i,
  output logic                      csr_rsp_valid_o,
  input  logic                      csr_rsp_ready_i,
  output logic [31:0]               csr_rsp_data_o,
  output logic [IdWidth-1:0]        csr_rsp_id_o,
  output logic                      csr_rsp_error_o,
  output logic [32*NumRwCsr-1:0]    csr_reg_set_o,
  output logic                      csr_reg_set_valid_o,
  input  logic                      csr_reg_set_ready_i,
  input  logic [32*NumRoCsr-1:0]    csr_reg_ro_set_i,
  input  logic                      acc_busy_i
);

  localparam int unsigned DecW     = dec_width(NumRwCsr, NumRoCsr);
  localparam int unsigned StartIdx = start_idx(NumRwCsr);
  localparam int unsigned PerfIdx  = perf_idx(NumRwCsr, NumRoCsr);

  logic [31:0]   r_csr [NumRwCsr];
  launch_state_e r_state;

  logic          w_hi_zero;
  logic [31:0]   w_idx;
  logic          w_is_rw;
  logic          w_is_start;
  logic          w_is_ro;
  logic          w_is_perf;
  logic          w_pending;
  logic [31:0]   w_rd_data;
  logic          w_rd_err;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_stall_wr;
  logic          w_stall_rd;
  logic          w_acc;
  logic          w_push;
  logic          w_wr;
  logic          w_launch;
  rsp_entry_t    w_push_entry;
  rsp_entry_t    w_head;
  logic          w_unused_id;

  assign w_hi_zero = ((csr_req_addr_i >> DecW) == '0);
  assign w_idx     = 32'(csr_req_addr_i[DecW-1:0]);
  assign w_pending = (r_state == LaunchPending);

  assign w_is_rw    = w_hi_zero && (w_idx < NumRwCsr);
  assign w_is_start = w_hi_zero && (w_idx == StartIdx);
  assign w_is_ro    = w_hi_zero && (w_idx > StartIdx)
                   && (w_idx <= StartIdx + NumRoCsr);
`ifdef SNAX_CSR_PERF_EN
  logic [31:0] r_perf;
  assign w_is_perf = w_hi_zero && (w_idx == PerfIdx);
`else
  assign w_is_perf = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    unique case (1'b1)
      w_is_rw: begin
        for (int i = 0; i < NumRwCsr; i++)
          if (w_idx == 32'(i)) w_rd_data = r_csr[i];
      end
      w_is_start: begin
        w_rd_data = {30'b0, w_pending, acc_busy_i};
      end
      w_is_ro: begin
        for (int i = 0; i < NumRoCsr; i++)
          if (w_idx == 32'(StartIdx + 1 + i))
            w_rd_data = csr_reg_ro_set_i[i*32 +: 32];
      end
`ifdef SNAX_CSR_PERF_EN
      w_is_perf: begin
        w_rd_data = r_perf;
      end
`endif
      default: begin
        w_rd_err = 1'b1;
      end
    endcase
  end

  // Ready is decided from request fields only, never from valid.
  assign w_pop      = csr_rsp_valid_o && csr_rsp_ready_i;
  assign w_stall_wr = csr_req_write_i && (w_is_rw || w_is_start)
                   && w_pending;
  assign w_stall_rd = !csr_req_write_i && w_full && !w_pop;
  assign csr_req_ready_o = !(w_stall_wr || w_stall_rd);

  assign w_acc    = csr_req_valid_i && csr_req_ready_o;
  assign w_push   = w_acc && !csr_req_write_i;
  assign w_wr     = w_acc && csr_req_write_i;
  assign w_launch = w_pending && csr_reg_set_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRwCsr; i++) r_csr[i] <= '0;
    end else if (w_wr && w_is_rw) begin
      for (int i = 0; i < NumRwCsr; i++)
        if (w_idx == 32'(i)) r_csr[i] <= csr_req_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= LaunchIdle;
    end else begin
      unique case (r_state)
        LaunchIdle:
          if (w_wr && w_is_start && csr_req_data_i[0])
            r_state <= LaunchPending;
        LaunchPending:
          if (csr_reg_set_ready_i) r_state <= LaunchIdle;
        default: r_state <= LaunchIdle;
      endcase
    end
  end

`ifdef SNAX_CSR_PERF_EN
  // Launch clear wins over the busy increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         r_perf <= '0;
    else if (w_launch)   r_perf <= '0;
    else if (acc_busy_i) r_perf <= r_perf + 32'd1;
  end
`endif

  for (genvar g = 0; g < NumRwCsr; g++) begin : g_set
    assign csr_reg_set_o[g*32 +: 32] = r_csr[g];
  end

  assign csr_reg_set_valid_o = w_pending;

  assign w_push_entry.data  = w_rd_data;
  assign w_push_entry.id    = MaxIdWidth'(csr_req_id_i);
  assign w_push_entry.error = w_rd_err;

  snax_csr_manager_fifo #(
    .DEPTH (RspFifoDepth),
    .DW    ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_i  (w_push_entry),
    .push_i  (w_push),
    .data_o  (w_head),
    .pop_i   (w_pop)
  );

  assign csr_rsp_valid_o = !w_empty;
  assign csr_rsp_data_o  = w_head.data;
  assign csr_rsp_id_o    = w_head.id[IdWidth-1:0];
  assign csr_rsp_error_o = w_head.error;
  assign w_unused_id     = ^(w_head.id >> IdWidth) ^ w_launch;

endmodule

// File: doc/snax_csr_manager.md
# snax_csr_manager

Parametrised CSR manager between the Snitch accelerator offload port and a SNAX accelerator. It stages NumRwCsr 32-bit configuration registers, launches the staged set to the accelerator with a valid/ready handshake on a START write, and exposes busy status and NumRoCsr accelerator status registers. Reads are returned in order through a response FIFO. It generalises the single-accelerator shell to arbitrary register counts and response depths, and adds optional performance counting.

## Interface
- NumRwCsr, 8: number of read/write configuration CSRs (≥1).
- NumRoCsr, 2: number of read-only status CSRs (≥0).
- RspFifoDepth, 2: read-response FIFO depth (≥1).
- IdWidth, 5: request/response tag width.
- CsrAddrWidth, 32: request address width. Only the low $clog2(NumRwCsr+NumRoCsr+2) bits are decoded. All higher bits must be zero, otherwise the address is out of range.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- csr_req_valid_i / csr_req_ready_o  in/out  1  request handshake.
- csr_req_addr_i  in  CsrAddrWidth  CSR index.
- csr_req_data_i  in  32  write data.
- csr_req_write_i  in  1  1 = write, 0 = read.
- csr_req_id_i  in  IdWidth  tag, echoed on the response.
- csr_rsp_valid_o / csr_rsp_ready_i  out/in  1  response handshake.
- csr_rsp_data_o  out  32  read data.
- csr_rsp_id_o  out  IdWidth  echoed tag.
- csr_rsp_error_o  out  1  out-of-range read.
- csr_reg_set_o  out  32*NumRwCsr  staged set, flat, CSR 0 in bits [31:0].
- csr_reg_set_valid_o / csr_reg_set_ready_i  out/in  1  launch handshake.
- csr_reg_ro_set_i  in  32*NumRoCsr  accelerator status, flat.
- acc_busy_i  in  1  accelerator busy.

## Operation
- Address map:
  - 0..NumRwCsr-1: RW CSRs.
  - S = NumRwCsr: START/STATUS.
  - S+1..S+NumRoCsr: RO CSRs.
  - S+NumRoCsr+1: PERF (macro only).
  - Anything else: out of range.
- Write to RW CSR: the register updates the cycle after acceptance.
- Write to S with data bit 0 = 1: sets pending.
- Write to S with bit 0 = 0, or a write to an RO, PERF or out-of-range address: accepted and ignored.
- Writes produce no response.
- Read: pushes {data, id, error} into the response FIFO.
  - RW CSR returns the staged value.
  - S returns {30'b0, pending, acc_busy_i}, sampled at acceptance.
  - RO CSR returns csr_reg_ro_set_i, sampled at acceptance.
  - Out of range returns data 0 with error = 1.
- Launch FSM has two states:
  - IDLE to PENDING on a START write.
  - PENDING to IDLE on csr_reg_set_valid_o && csr_reg_set_ready_i.
  - csr_reg_set_valid_o = (state == PENDING).
  - csr_reg_set_o is always the RW registers. They are stable while PENDING, because writes are stalled then.
- csr_req_ready_o is low when either holds:
  - a write to an RW CSR or S arrives while PENDING;
  - a read arrives while the FIFO is full and not popping in the same cycle.
  Otherwise it is high.
- Reads are served while PENDING. The decision is combinational on request fields, so ready must not depend on valid.

## Timing
- Reset values:
  - all RW CSRs = 0; FSM = IDLE; FIFO empty; PERF = 0.
  - csr_req_ready_o = 1 (when no request is stalling).
  - csr_rsp_valid_o = 0, csr_rsp_data_o = 0, csr_rsp_id_o = 0, csr_rsp_error_o = 0.
  - csr_reg_set_valid_o = 0, csr_reg_set_o = 0.
- Read latency: a response is valid the cycle after acceptance at the earliest (registered FIFO, no fall-through).
- START-to-launch: csr_reg_set_valid_o rises the cycle after the START write is accepted. It holds until ready. A same-cycle ready completes the launch in that cycle.
- FIFO full with simultaneous pop: a new read is accepted in the same cycle. Order is preserved.
- csr_rsp_valid_o stays high and payload stays stable until csr_rsp_ready_i.
- Reset mid-operation: FSM returns to IDLE, FIFO flushes, registers clear, and there is no spurious launch.

## Configuration
- SNAX_CSR_PERF_EN defined:
  - adds a 32-bit PERF register at S+NumRoCsr+1;
  - PERF increments every cycle acc_busy_i = 1 and wraps at 2^32;
  - PERF clears to 0 on the launch handshake, with the clear taking priority over the increment;
  - PERF is readable, and writes to it are ignored.
- SNAX_CSR_PERF_EN undefined: no counter exists, and that address is out of range (error = 1).

## Structure
- Shared package snax_csr_pkg holds:
  - the rsp entry typedef {data, id, error};
  - the launch FSM state enum;
  - functions for S and the PERF offset, as functions of NumRwCsr and NumRoCsr.
- Sub-module: common_cells fifo_v3 as the response queue (DEPTH = RspFifoDepth, FALL_THROUGH = 0).

## Test plan
- Reset, then write 0xDEADBEEF to CSR 3 and read it back (id 7) -> rsp data 0xDEADBEEF, id 7, error 0, one cycle after the read is accepted.
- Write CSRs 0..7, then write 1 to S (8) with csr_reg_set_ready_i held low for 5 cycles. Expect:
  - valid high for 6 cycles and the set stable;
  - a write to CSR 0 during that window stalls;
  - a read of S returns 0x2.
- RspFifoDepth = 2 with csr_rsp_ready_i = 0 and three back-to-back reads -> the third stalls until one pop, and responses keep issue order.
- Read address 15 with NumRwCsr = 8, NumRoCsr = 2 -> data 0, error 1.
- With SNAX_CSR_PERF_EN and acc_busy_i high for 10 cycles, read PERF -> 10. Launch, then read again -> 0 plus any busy cycles since the launch.
- Assert rst_ni during PENDING -> csr_reg_set_valid_o = 0 immediately, the FIFO is empty, and CSR 3 reads 0.
